// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths and the MAC sequencer state type.
package cnn_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ACC_W  = 31;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StOut
  } seq_state_t;

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// Bundle of the sequencer's job, operand-memory, PE and result signals.
// master: the sequencer side; slave: controller / memory / PE / consumer side.
interface pe_mac_sequencer_if #(
  parameter int unsigned DATA_W = cnn_pkg::DEF_DATA_W,
  parameter int unsigned ACC_W  = cnn_pkg::DEF_ACC_W,
  parameter int unsigned LEN_W  = cnn_pkg::DEF_LEN_W
);

  // Job control
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              busy;
  // Operand memory
  logic              rd_en;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  // Processing element
  logic [DATA_W-1:0] pe_input1;
  logic [DATA_W-1:0] pe_input2;
  logic [ACC_W-1:0]  pe_initsum;
  logic [ACC_W-1:0]  pe_result;
  // Result stream
  logic              out_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_ready;

  modport master (
    input  start, len, rd_data_a, rd_data_b, pe_result, out_ready,
    output busy, rd_en, rd_addr, pe_input1, pe_input2, pe_initsum, out_valid, out_data
  );

  modport slave (
    output start, len, rd_data_a, rd_data_b, pe_result, out_ready,
    input  busy, rd_en, rd_addr, pe_input1, pe_input2, pe_initsum, out_valid, out_data
  );

endinterface

// File: rtl/pe_mac_sequencer.sv
// Drives an external PE through an N-term dot product: reads operand pairs from a
// 1-cycle-latency memory, loops each product back through pe_initsum, and offers the
// final sum on a valid/ready output.
// Optional feature macro: PE_MAC_SEQ_RELU_EN (clamp negative results to zero at output).
module pe_mac_sequencer
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned LEN_W  = DEF_LEN_W
) (
  input logic                clk,
  input logic                rst_n,
  pe_mac_sequencer_if.master bus
);

  seq_state_t        r_state;
  seq_state_t        w_state_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_v;
  logic [ACC_W-1:0]  r_acc;

  logic              w_rd_en;
  logic              w_last;
  logic              w_accept;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;
  logic [ACC_W-1:0]  w_out_data;

  assign w_accept = (r_state == StIdle) && bus.start;
  // Last read of the job is the one issuing index N-1
  assign w_last   = (r_cnt == r_len - LEN_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = (bus.len == '0) ? StOut : StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        w_state_next = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // Job length, address counter, data-valid pipe bit and accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= '0;
      r_cnt <= '0;
      r_v   <= 1'b0;
      r_acc <= '0;
    end else begin
      r_v <= w_rd_en;
      if (w_accept) begin
        r_len <= bus.len;
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        if (w_rd_en) begin
          r_cnt <= r_cnt + LEN_W'(1);
        end
        // PE already wraps mod 2^ACC_W; take its result verbatim
        if (r_v) begin
          r_acc <= bus.pe_result;
        end
      end
    end
  end

  // Result shaping; the internal accumulator is never modified here
  always_comb begin
`ifdef PE_MAC_SEQ_RELU_EN
    w_out_data = r_acc[ACC_W-1] ? '0 : r_acc;
`else
    w_out_data = r_acc;
`endif
  end

  // Outputs decoded from state and the data-valid bit; everything idles at zero
  always_comb begin
    w_rd_en        = (r_state == StRun);
    w_op_a         = r_v ? bus.rd_data_a : '0;
    w_op_b         = r_v ? bus.rd_data_b : '0;
    bus.busy       = (r_state != StIdle);
    bus.rd_en      = w_rd_en;
    bus.rd_addr    = w_rd_en ? r_cnt : '0;
    bus.pe_input1  = w_op_a;
    bus.pe_input2  = w_op_b;
    bus.pe_initsum = r_v ? r_acc : '0;
    bus.out_valid  = (r_state == StOut);
    bus.out_data   = (r_state == StOut) ? w_out_data : '0;
  end

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Self-checking bench for pe_mac_sequencer: operand memory and PE models, a
// cycle-timeline reference model checked every cycle, and directed jobs with
// hand-computed results.
module tb_pe_mac_sequencer;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 31;
  localparam int unsigned LEN_W  = 8;

  logic clk;
  logic rst_n;

  pe_mac_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) bus ();

  pe_mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand memory: one-cycle read latency
  logic [DATA_W-1:0] mem_a [256];
  logic [DATA_W-1:0] mem_b [256];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_data_a <= mem_a[bus.rd_addr];
      bus.rd_data_b <= mem_b[bus.rd_addr];
    end
  end

  // Combinational PE: input1*input2+initsum mod 2^ACC_W
  logic signed [31:0] pe_prod;
  always_comb begin
    pe_prod       = $signed(bus.pe_input1) * $signed(bus.pe_input2);
    bus.pe_result = pe_prod[ACC_W-1:0] + bus.pe_initsum;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Exact dot product of the first j terms, reduced mod 2^ACC_W
  function automatic logic [ACC_W-1:0] partial(input int j);
    longint s;
    s = 0;
    for (int i = 0; i < j; i++) begin
      s += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
    end
    return s[ACC_W-1:0];
  endfunction

  function automatic logic [ACC_W-1:0] final_val(input int n);
    logic [ACC_W-1:0] p;
    p = partial(n);
`ifdef PE_MAC_SEQ_RELU_EN
    if (p[ACC_W-1]) p = '0;
`endif
    return p;
  endfunction

  function automatic int ov_cycle(input int n);
    return (n == 0) ? 1 : n + 2;
  endfunction

  // Timeline model: m_k is the index of the current cycle after the start edge
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_n    = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_n    = 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1'b1;
        m_k    = 1;
        m_n    = int'(bus.len);
      end
    end else if (m_k >= ov_cycle(m_n) && bus.out_ready) begin
      m_busy = 1'b0;
    end else begin
      m_k++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    bit               e_rd_en;
    bit               e_v;
    bit               e_ov;
    logic [63:0]      e_addr;
    logic [DATA_W-1:0] e_in1;
    logic [DATA_W-1:0] e_in2;
    logic [ACC_W-1:0] e_init;
    logic [ACC_W-1:0] e_od;
    if (cmp_en) begin
      e_rd_en = m_busy && (m_k >= 1) && (m_k <= m_n);
      e_addr  = e_rd_en ? 64'(m_k - 1) : 64'd0;
      e_v     = m_busy && (m_k >= 2) && (m_k <= m_n + 1);
      e_in1   = e_v ? mem_a[m_k-2] : '0;
      e_in2   = e_v ? mem_b[m_k-2] : '0;
      e_init  = e_v ? partial(m_k - 2) : '0;
      e_ov    = m_busy && (m_k >= ov_cycle(m_n));
      e_od    = e_ov ? final_val(m_n) : '0;
      chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
      chk("cyc_rd_en", 64'(bus.rd_en), 64'(e_rd_en));
      chk("cyc_rd_addr", 64'(bus.rd_addr), e_addr);
      chk("cyc_pe_input1", 64'(bus.pe_input1), 64'(e_in1));
      chk("cyc_pe_input2", 64'(bus.pe_input2), 64'(e_in2));
      chk("cyc_pe_initsum", 64'(bus.pe_initsum), 64'(e_init));
      chk("cyc_out_valid", 64'(bus.out_valid), 64'(e_ov));
      chk("cyc_out_data", 64'(bus.out_data), 64'(e_od));
    end
  end

  // Issue one job, wait (bounded) for out_valid, check latency/result literals
  task automatic run_job(input int n, input int exp_cyc, input logic [ACC_W-1:0] exp_data,
                         input string nm);
    int cyc;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = n[LEN_W-1:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({nm, "_rd_en_c1"}, 64'(bus.rd_en), 64'(n != 0));
    cyc = 1;
    while (!bus.out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, "_latency"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, "_data"}, 64'(bus.out_data), 64'(exp_data));
    if (bus.out_ready) begin
      @(posedge clk); #1;
      chk({nm, "_busy_after"}, 64'(bus.busy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_rd_en", 64'(bus.rd_en), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // N=3 mixed signs and max positive square
    mem_a[0] = 16'h0002; mem_b[0] = 16'h0008;
    mem_a[1] = 16'hFFFF; mem_b[1] = 16'hFFFF;
    mem_a[2] = 16'h7FFF; mem_b[2] = 16'h7FFF;
    run_job(3, 5, 31'h3FFF_0012, "n3");

    // N=1 negative result
    mem_a[0] = 16'hFFFF; mem_b[0] = 16'h0001;
`ifdef PE_MAC_SEQ_RELU_EN
    run_job(1, 3, 31'h0000_0000, "n1_neg");
`else
    run_job(1, 3, 31'h7FFF_FFFF, "n1_neg");
`endif

    // Empty job
    run_job(0, 1, 31'h0, "len0");

    // N=2 wrap to zero, held under backpressure with ignored start pulses
    mem_a[0] = 16'h8000; mem_b[0] = 16'h8000;
    mem_a[1] = 16'h8000; mem_b[1] = 16'h8000;
    bus.out_ready = 1'b0;
    run_job(2, 4, 31'h0, "wrap");
    for (int i = 0; i < 10; i++) begin
      bus.start = i[0];
      bus.len   = 8'(i + 3);
      @(posedge clk); #1;
      chk("wrap_hold_valid", 64'(bus.out_valid), 64'd1);
      chk("wrap_hold_data", 64'(bus.out_data), 64'd0);
    end
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("wrap_hs_start_ignored_busy", 64'(bus.busy), 64'd0);
    chk("wrap_hs_start_ignored_valid", 64'(bus.out_valid), 64'd0);

    // Reset in the middle of an N=8 job
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 16'(i + 1);
      mem_b[i] = 16'(3 * i + 1);
    end
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 8'd8;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_rd_en", 64'(bus.rd_en), 64'd0);
    chk("midrst_rd_addr", 64'(bus.rd_addr), 64'd0);
    chk("midrst_pe_input1", 64'(bus.pe_input1), 64'd0);
    chk("midrst_pe_initsum", 64'(bus.pe_initsum), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus.out_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_a[0] = 16'h0002; mem_b[0] = 16'h0003;
    run_job(1, 3, 31'd6, "post_rst");

    // Back-to-back jobs: accumulator must restart from zero
    mem_a[0] = 16'h0001; mem_b[0] = 16'h0001;
    mem_a[1] = 16'h0001; mem_b[1] = 16'h0001;
    run_job(2, 4, 31'd2, "b2b_first");
    run_job(2, 4, 31'd2, "b2b_second");

    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
